id_ex_hazard_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection, branch flush, and stall/flush event counters. It captures decoded instruction fields at the end of ID and presents them to EX. Its `Rs1_EX`, `Rs2_EX` and `Rd_EX` outputs feed the EX-stage forwarding unit directly. It also drives `PCWrite` and `IFIDWrite` back to the IF and ID stages.

---
 rtl/id_ex_hazard_stage_if.sv | 45 ++++
 rtl/id_ex_hazard_stage.sv | 116 +++++++++++
 tb/tb_id_ex_hazard_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_hazard_stage_if.sv
// ID/EX stage bundle: decoded ID fields in, registered EX fields and
// IF/ID control feedback out.
interface id_ex_hazard_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1_ID, Rs2_ID, Rd_ID;
    logic             Uses_Rs1_ID, Uses_Rs2_ID;
    logic [XLEN-1:0]  RD1_ID, RD2_ID, Imm_ID, PC_ID;
    logic             RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID;
    logic [3:0]       ALUOp_ID;
    logic             Valid_ID;
    logic             Flush_EX;
    logic             Hold;

    logic [4:0]       Rs1_EX, Rs2_EX, Rd_EX;
    logic [XLEN-1:0]  RD1_EX, RD2_EX, Imm_EX, PC_EX;
    logic             RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX;
    logic [3:0]       ALUOp_EX;
    logic             Valid_EX;
    logic             PCWrite, IFIDWrite, Stall_ID;
    logic [CNT_W-1:0] StallCount, FlushCount;

    // Driven by the decode side of the pipeline.
    modport master (
        output Rs1_ID, Rs2_ID, Rd_ID, Uses_Rs1_ID, Uses_Rs2_ID,
               RD1_ID, RD2_ID, Imm_ID, PC_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID,
               ALUOp_ID, Valid_ID, Flush_EX, Hold,
        input  Rs1_EX, Rs2_EX, Rd_EX, RD1_EX, RD2_EX, Imm_EX, PC_EX,
               RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX,
               ALUOp_EX, Valid_EX, PCWrite, IFIDWrite, Stall_ID, StallCount, FlushCount
    );

    // The ID/EX stage itself.
    modport slave (
        input  Rs1_ID, Rs2_ID, Rd_ID, Uses_Rs1_ID, Uses_Rs2_ID,
               RD1_ID, RD2_ID, Imm_ID, PC_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID,
               ALUOp_ID, Valid_ID, Flush_EX, Hold,
        output Rs1_EX, Rs2_EX, Rd_EX, RD1_EX, RD2_EX, Imm_EX, PC_EX,
               RegWrite_EX, MemRead_EX, MemWrite_EX, MemtoReg_EX, ALUSrc_EX, Branch_EX,
               ALUOp_EX, Valid_EX, PCWrite, IFIDWrite, Stall_ID, StallCount, FlushCount
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and saturating
// stall/flush event counters. Bubbles zero the register indices so the EX
// forwarding unit can never match against a killed slot.
module id_ex_hazard_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    id_ex_hazard_stage_if.slave   bus
);
    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            branch;
        logic [3:0]      alu_op;
        logic            valid;
    } stage_t;

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             pc_write, ifid_write, stall_id;

    // Hazard detection and next-state selection (Hold > Flush > load-use > advance).
    always_comb begin
        load_use = stage_q.mem_read & stage_q.valid & (stage_q.rd != 5'd0) & bus.Valid_ID &
                   ((bus.Uses_Rs1_ID & (bus.Rs1_ID == stage_q.rd)) |
                    (bus.Uses_Rs2_ID & (bus.Rs2_ID == stage_q.rd)));

        stage_d     = stage_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        stall_id    = 1'b0;

        if (bus.Hold) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (bus.Flush_EX) begin
            // The ID instruction is being killed, so a pending load-use is moot.
            stage_d = '0;
            if (flush_cnt_q != {CNT_W{1'b1}})
                flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (load_use) begin
            stage_d    = '0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_id   = 1'b1;
            if (stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stage_d.rs1        = bus.Rs1_ID;
            stage_d.rs2        = bus.Rs2_ID;
            stage_d.rd         = bus.Rd_ID;
            stage_d.rd1        = bus.RD1_ID;
            stage_d.rd2        = bus.RD2_ID;
            stage_d.imm        = bus.Imm_ID;
            stage_d.pc         = bus.PC_ID;
            stage_d.reg_write  = bus.RegWrite_ID;
            stage_d.mem_read   = bus.MemRead_ID;
            stage_d.mem_write  = bus.MemWrite_ID;
            stage_d.mem_to_reg = bus.MemtoReg_ID;
            stage_d.alu_src    = bus.ALUSrc_ID;
            stage_d.branch     = bus.Branch_ID;
            stage_d.alu_op     = bus.ALUOp_ID;
            stage_d.valid      = bus.Valid_ID;
        end
    end

    // Pipeline register and event counters, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stage_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.Rs1_EX      = stage_q.rs1;
    assign bus.Rs2_EX      = stage_q.rs2;
    assign bus.Rd_EX       = stage_q.rd;
    assign bus.RD1_EX      = stage_q.rd1;
    assign bus.RD2_EX      = stage_q.rd2;
    assign bus.Imm_EX      = stage_q.imm;
    assign bus.PC_EX       = stage_q.pc;
    assign bus.RegWrite_EX = stage_q.reg_write;
    assign bus.MemRead_EX  = stage_q.mem_read;
    assign bus.MemWrite_EX = stage_q.mem_write;
    assign bus.MemtoReg_EX = stage_q.mem_to_reg;
    assign bus.ALUSrc_EX   = stage_q.alu_src;
    assign bus.Branch_EX   = stage_q.branch;
    assign bus.ALUOp_EX    = stage_q.alu_op;
    assign bus.Valid_EX    = stage_q.valid;
    assign bus.PCWrite     = pc_write;
    assign bus.IFIDWrite   = ifid_write;
    assign bus.Stall_ID    = stall_id;
    assign bus.StallCount  = stall_cnt_q;
    assign bus.FlushCount  = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage with a cycle-level reference model
// compared on every falling edge plus hand-computed spot checks.
module tb_id_ex_hazard_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   seq = 0;

    always #5 CLK = ~CLK;

    id_ex_hazard_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bif ();
    id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST_n(RST_n), .bus(bif));

    // Reference: what EX must hold, plus plain integer event counts.
    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc;
        logic [5:0]  ctl;   // RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch
        logic [3:0]  op;
        logic        valid;
    } ex_t;

    ex_t m;
    int  m_stalls, m_flushes;

    function automatic ex_t empty_slot();
        ex_t e;
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc = 0;
        e.ctl = 0; e.op = 0; e.valid = 0;
        return e;
    endfunction

    // Does the instruction in ID need a register the EX load has not produced yet?
    function automatic bit model_load_use();
        if (!(m.valid && m.ctl[4] && m.rd != 0 && bif.Valid_ID)) return 0;
        return (bif.Uses_Rs1_ID && bif.Rs1_ID == m.rd) || (bif.Uses_Rs2_ID && bif.Rs2_ID == m.rd);
    endfunction

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m = empty_slot();
            m_stalls = 0;
            m_flushes = 0;
        end else if (bif.Hold) begin
            // frozen
        end else if (bif.Flush_EX) begin
            m = empty_slot();
            m_flushes = (m_flushes + 1 > CMAX) ? CMAX : m_flushes + 1;
        end else if (model_load_use()) begin
            m = empty_slot();
            m_stalls = (m_stalls + 1 > CMAX) ? CMAX : m_stalls + 1;
        end else begin
            m.rs1 = bif.Rs1_ID; m.rs2 = bif.Rs2_ID; m.rd = bif.Rd_ID;
            m.rd1 = bif.RD1_ID; m.rd2 = bif.RD2_ID; m.imm = bif.Imm_ID; m.pc = bif.PC_ID;
            m.ctl = {bif.RegWrite_ID, bif.MemRead_ID, bif.MemWrite_ID,
                     bif.MemtoReg_ID, bif.ALUSrc_ID, bif.Branch_ID};
            m.op = bif.ALUOp_ID;
            m.valid = bif.Valid_ID;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge CLK) begin : cmp
        bit lu;
        bit pcw, stl;
        lu  = model_load_use();
        pcw = bif.Hold ? 0 : (bif.Flush_EX ? 1 : !lu);
        stl = !bif.Hold && !bif.Flush_EX && lu;
        chk("ex_idx",  {bif.Rs1_EX, bif.Rs2_EX, bif.Rd_EX}, {m.rs1, m.rs2, m.rd});
        chk("ex_rd1",  bif.RD1_EX, m.rd1);
        chk("ex_rd2",  bif.RD2_EX, m.rd2);
        chk("ex_imm",  bif.Imm_EX, m.imm);
        chk("ex_pc",   bif.PC_EX, m.pc);
        chk("ex_ctl",  {bif.RegWrite_EX, bif.MemRead_EX, bif.MemWrite_EX,
                        bif.MemtoReg_EX, bif.ALUSrc_EX, bif.Branch_EX}, m.ctl);
        chk("ex_op",   bif.ALUOp_EX, m.op);
        chk("ex_valid", bif.Valid_EX, m.valid);
        chk("pcwrite", bif.PCWrite, pcw);
        chk("ifidwrite", bif.IFIDWrite, pcw);
        chk("stall_id", bif.Stall_ID, stl);
        chk("stall_cnt", bif.StallCount, m_stalls);
        chk("flush_cnt", bif.FlushCount, m_flushes);
    end

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input bit u1, input bit u2, input bit mr, input bit v);
        seq++;
        bif.Rs1_ID = rs1; bif.Rs2_ID = rs2; bif.Rd_ID = rd;
        bif.Uses_Rs1_ID = u1; bif.Uses_Rs2_ID = u2;
        bif.RD1_ID = 32'h1000_0000 | 32'(seq);
        bif.RD2_ID = ~(32'h2000_0000 | 32'(seq));
        bif.Imm_ID = 32'(seq * 4);
        bif.PC_ID  = 32'h400 + 32'(seq * 4);
        bif.RegWrite_ID = 1'b1; bif.MemRead_ID = mr; bif.MemWrite_ID = seq[2];
        bif.MemtoReg_ID = mr; bif.ALUSrc_ID = seq[0]; bif.Branch_ID = seq[1];
        bif.ALUOp_ID = 4'(seq);
        bif.Valid_ID = v;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bif.Flush_EX = 0;
        bif.Hold = 0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_valid", bif.Valid_EX, 0);
        chk("rst_pcw", bif.PCWrite, 1);
        RST_n = 1;
        #1;
        chk("post_rst_stall", bif.Stall_ID, 0);

        // load-use on Rs1: lw x5 then add x6,x5,x7
        set_id(1, 0, 5, 1, 0, 1, 1);
        cyc();
        set_id(5, 7, 6, 1, 1, 0, 1);
        #1;
        chk("lu_stall", bif.Stall_ID, 1);
        chk("lu_pcw", bif.PCWrite, 0);
        chk("lu_ifidw", bif.IFIDWrite, 0);
        cyc();
        chk("lu_bub_valid", bif.Valid_EX, 0);
        chk("lu_bub_rd", bif.Rd_EX, 0);
        chk("lu_cnt", bif.StallCount, 1);
        cyc();
        chk("lu_adv_rs1", bif.Rs1_EX, 5);
        chk("lu_adv_rd", bif.Rd_EX, 6);
        chk("lu_adv_valid", bif.Valid_EX, 1);

        // no false stall: unused Rs2 matches, then a load to x0
        set_id(3, 0, 9, 1, 0, 1, 1);
        cyc();
        set_id(3, 9, 11, 1, 0, 0, 1);
        #1;
        chk("nouse_stall", bif.Stall_ID, 0);
        cyc();
        chk("nouse_rd", bif.Rd_EX, 11);
        set_id(2, 0, 0, 1, 0, 1, 1);
        cyc();
        set_id(0, 0, 4, 1, 1, 0, 1);
        #1;
        chk("x0_stall", bif.Stall_ID, 0);
        cyc();
        chk("x0_rd", bif.Rd_EX, 4);

        // flush beats load-use
        set_id(1, 1, 8, 1, 0, 1, 1);
        cyc();
        set_id(8, 0, 3, 1, 0, 0, 1);
        bif.Flush_EX = 1;
        #1;
        chk("fl_pcw", bif.PCWrite, 1);
        chk("fl_stall", bif.Stall_ID, 0);
        cyc();
        bif.Flush_EX = 0;
        chk("fl_valid", bif.Valid_EX, 0);
        chk("fl_cnt", bif.FlushCount, 1);
        chk("fl_stallcnt", bif.StallCount, 1);

        // hold with flush, changing ID inputs
        set_id(2, 3, 10, 1, 1, 0, 1);
        cyc();
        bif.Hold = 1;
        bif.Flush_EX = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(5'(i), 5'(i + 1), 5'(20 + i), 1, 1, i[0], 1);
            #1;
            chk("hold_pcw", bif.PCWrite, 0);
            chk("hold_ifidw", bif.IFIDWrite, 0);
            cyc();
            chk("hold_rd", bif.Rd_EX, 10);
            chk("hold_flcnt", bif.FlushCount, 1);
        end
        bif.Hold = 0;
        bif.Flush_EX = 0;
        set_id(4, 4, 13, 1, 1, 0, 1);
        cyc();
        chk("hold_rel_rd", bif.Rd_EX, 13);

        // self-dependent load lw x12,(x12): alternates capture / stall
        set_id(12, 0, 12, 1, 0, 1, 1);
        repeat (13) cyc();
        chk("pre_rst_cnt", bif.StallCount, 7);
        chk("pre_rst_valid", bif.Valid_EX, 1);

        // async reset between edges
        #2;
        RST_n = 0;
        #1;
        chk("arst_valid", bif.Valid_EX, 0);
        chk("arst_cnt", bif.StallCount, 0);
        chk("arst_rd", bif.Rd_EX, 0);
        chk("arst_memrd", bif.MemRead_EX, 0);
        chk("arst_pcw", bif.PCWrite, 1);
        chk("arst_stall", bif.Stall_ID, 0);
        @(negedge CLK);
        #2;
        RST_n = 1;

        // saturation: 17+ stalls on a 4-bit counter
        repeat (40) cyc();
        chk("sat_cnt", bif.StallCount, 15);
        chk("sat_flcnt", bif.FlushCount, 0);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
